// File: rtl/dcache_if.sv
// CPU load/store port and word-wide data-memory port of the direct-mapped data cache.
interface dcache_if;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_address;
    logic [7:0]  cpu_writedata;
    logic [7:0]  cpu_readdata;
    logic        cpu_busywait;
    logic        dm_read;
    logic        dm_write;
    logic [5:0]  dm_address;
    logic [31:0] dm_writedata;
    logic [31:0] dm_readdata;
    logic        dm_busywait;

    // Cache side
    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_writedata, dm_readdata, dm_busywait,
        output cpu_readdata, cpu_busywait, dm_read, dm_write, dm_address, dm_writedata
    );

    // CPU + memory side
    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_writedata, dm_readdata, dm_busywait,
        input  cpu_readdata, cpu_busywait, dm_read, dm_write, dm_address, dm_writedata
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 blocks x 4 bytes,
// byte-wide CPU port, 32-bit block-wide memory port.
module dcache (
    input logic     CLK,
    input logic     RESET,
    dcache_if.slave bus
);
    localparam int unsigned NUM_BLOCKS = 8;
    localparam int unsigned TAG_W      = 3;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned OFS_W      = 2;
    localparam int unsigned BLOCK_W    = 32;
    localparam int unsigned BYTE_W     = 8;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

    state_t state, next_state;

    logic [BLOCK_W-1:0] data_q [NUM_BLOCKS];
    logic [TAG_W-1:0]   tag_q  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFS_W-1:0] offset;
    logic hit;
    logic request;
    logic write_hit;
    logic fill;

    assign tag     = bus.cpu_address[7:5];
    assign index   = bus.cpu_address[4:2];
    assign offset  = bus.cpu_address[1:0];
    assign hit     = valid_q[index] && (tag_q[index] == tag);
    assign request = bus.cpu_read || bus.cpu_write;

    // A simultaneous read+write is serviced as a write
    assign write_hit = bus.cpu_write && (state == IDLE) && hit;
    assign fill      = (state == FETCH) && !bus.dm_busywait;

    assign bus.cpu_readdata = data_q[index][{offset, 3'b000} +: BYTE_W];
    assign bus.cpu_busywait = RESET && request && !((state == IDLE) && hit);

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and memory-port decode
    always_comb begin
        next_state       = state;
        bus.dm_read      = 1'b0;
        bus.dm_write     = 1'b0;
        bus.dm_address   = 6'(0);
        bus.dm_writedata = BLOCK_W'(0);
        case (state)
            IDLE: begin
                if (request && !hit)
                    next_state = (valid_q[index] && dirty_q[index]) ? WRITEBACK : FETCH;
            end
            WRITEBACK: begin
                bus.dm_write     = 1'b1;
                bus.dm_address   = {tag_q[index], index};
                bus.dm_writedata = data_q[index];
                if (!bus.dm_busywait) next_state = FETCH;
            end
            FETCH: begin
                bus.dm_read    = 1'b1;
                bus.dm_address = bus.cpu_address[7:2];
                if (!bus.dm_busywait) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Block storage: byte writes on store hits, whole-block install on fill
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= NUM_BLOCKS'(0);
            dirty_q <= NUM_BLOCKS'(0);
            for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
                data_q[i] <= BLOCK_W'(0);
                tag_q[i]  <= TAG_W'(0);
            end
        end else if (fill) begin
            data_q[index]  <= bus.dm_readdata;
            tag_q[index]   <= tag;
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (write_hit) begin
            data_q[index][{offset, 3'b000} +: BYTE_W] <= bus.cpu_writedata;
            dirty_q[index] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: vector table through a scoreboard queue,
// plus a hand-written reset-during-fetch sequence and an index sweep.
module tb_dcache;
    localparam int unsigned LAT = 3;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_data;
        logic        exp_wb;
        logic [5:0]  exp_wb_addr;
        logic [31:0] exp_wb_data;
        logic        exp_fetch;
        logic [5:0]  exp_fe_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    dcache_if bus ();
    dcache dut (.CLK(clk), .RESET(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Data memory model: busywait rises with a strobe and clears after LAT cycles
    logic [31:0] mem [64];
    logic        loaded = 1'b0;
    int unsigned cnt = 0;

    function automatic logic [31:0] init_word(int a);
        logic [5:0] b;
        b = 6'(a);
        if (a == 1) return 32'h44332211;
        return {2'b11, b, 2'b10, b, 2'b01, b, 2'b00, b};
    endfunction

    always @(posedge clk) begin
        if (!loaded) begin
            for (int a = 0; a < 64; a++) mem[a] <= init_word(a);
            loaded <= 1'b1;
        end else if (bus.dm_read || bus.dm_write) begin
            if (cnt == LAT) begin
                if (bus.dm_write) mem[bus.dm_address] <= bus.dm_writedata;
                cnt <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    assign bus.dm_busywait = (bus.dm_read || bus.dm_write) && (cnt != LAT);
    assign bus.dm_readdata = mem[bus.dm_address];

    // Coherent byte view of the address space as the CPU should see it
    logic [7:0] ref_b [256];
    vec_t sb [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(logic [5:0] blk);
        int base;
        base = int'(blk) * 4;
        return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
    endfunction

    function automatic vec_t mk(string name, logic rd, logic wr, logic [7:0] addr,
                                logic [7:0] wdata, logic [7:0] exp_data,
                                logic exp_wb, logic [5:0] wb_addr, logic [31:0] wb_data,
                                logic exp_fetch);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_data = exp_data; v.exp_wb = exp_wb; v.exp_wb_addr = wb_addr;
        v.exp_wb_data = wb_data; v.exp_fetch = exp_fetch; v.exp_fe_addr = addr[7:2];
        return v;
    endfunction

    task automatic apply(vec_t v);
        vec_t e;
        int busy = 0, wb_cyc = 0, fe_cyc = 0, both = 0, unstable = 0;
        int first_wb = -1, first_fe = -1, t = 0;
        logic [5:0]  wb_addr = '0, fe_addr = '0;
        logic [31:0] wb_data = '0;
        logic done = 1'b0;
        sb.push_back(v);
        bus.cpu_read      = v.rd;
        bus.cpu_write     = v.wr;
        bus.cpu_address   = v.addr;
        bus.cpu_writedata = v.wdata;
        while (!done && t < 200) begin
            @(negedge clk);
            if (bus.dm_read && bus.dm_write) both++;
            if (bus.dm_write) begin
                if (first_wb < 0) begin
                    first_wb = t; wb_addr = bus.dm_address; wb_data = bus.dm_writedata;
                end else if (bus.dm_address !== wb_addr || bus.dm_writedata !== wb_data) unstable++;
                wb_cyc++;
            end
            if (bus.dm_read) begin
                if (first_fe < 0) begin
                    first_fe = t; fe_addr = bus.dm_address;
                end else if (bus.dm_address !== fe_addr) unstable++;
                fe_cyc++;
            end
            if (!bus.cpu_busywait) done = 1'b1;
            else busy++;
            t++;
        end
        e = sb.pop_front();
        check({e.name, " completes"}, 32'(done), 32'd1);
        if (e.rd && !e.wr) check({e.name, " readdata"}, 32'(bus.cpu_readdata), 32'(e.exp_data));
        check({e.name, " writeback"}, 32'(wb_cyc > 0), 32'(e.exp_wb));
        check({e.name, " fetch"}, 32'(fe_cyc > 0), 32'(e.exp_fetch));
        check({e.name, " strobe overlap"}, 32'(both), 32'd0);
        check({e.name, " dm stable"}, 32'(unstable), 32'd0);
        if (e.exp_wb) begin
            check({e.name, " wb addr"}, 32'(wb_addr), 32'(e.exp_wb_addr));
            check({e.name, " wb data"}, wb_data, e.exp_wb_data);
            check({e.name, " wb before fetch"}, 32'(first_wb < first_fe), 32'd1);
        end
        if (e.exp_fetch) check({e.name, " fetch addr"}, 32'(fe_addr), 32'(e.exp_fe_addr));
        check({e.name, " stall cycles"}, 32'(busy),
              (e.exp_wb || e.exp_fetch) ? 32'(wb_cyc + fe_cyc + 1) : 32'd0);
        @(posedge clk);
        #1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        if (e.wr) ref_b[e.addr] = e.wdata;
    endtask

    task automatic rebuild_ref();
        for (int a = 0; a < 64; a++)
            for (int k = 0; k < 4; k++) ref_b[a*4+k] = mem[a][8*k +: 8];
    endtask

    initial begin
        vec_t tbl [10];
        vec_t v;
        logic [7:0] a;
        int t;

        for (int w = 0; w < 64; w++)
            for (int k = 0; k < 4; k++) ref_b[w*4+k] = init_word(w) >> (8*k);

        tbl[0] = mk("cold read 05",   1, 0, 8'h05, 8'h00, 8'h22, 0, 6'h00, 32'h0, 1);
        tbl[1] = mk("write hit 06",   0, 1, 8'h06, 8'hAB, 8'h00, 0, 6'h00, 32'h0, 0);
        tbl[2] = mk("read hit 06",    1, 0, 8'h06, 8'h00, 8'hAB, 0, 6'h00, 32'h0, 0);
        tbl[3] = mk("conflict 26",    1, 0, 8'h26, 8'h00, 8'h89, 1, 6'h01, 32'h44AB2211, 1);
        tbl[4] = mk("read hit 24",    1, 0, 8'h24, 8'h00, 8'h09, 0, 6'h00, 32'h0, 0);
        tbl[5] = mk("clean miss 45",  1, 0, 8'h45, 8'h00, 8'h51, 0, 6'h00, 32'h0, 1);
        tbl[6] = mk("write hit 47",   0, 1, 8'h47, 8'h5C, 8'h00, 0, 6'h00, 32'h0, 0);
        tbl[7] = mk("dirty miss 07",  1, 0, 8'h07, 8'h00, 8'h44, 1, 6'h11, 32'h5C915111, 1);
        tbl[8] = mk("rd+wr 07",       1, 1, 8'h07, 8'h77, 8'h00, 0, 6'h00, 32'h0, 0);
        tbl[9] = mk("read hit 07",    1, 0, 8'h07, 8'h00, 8'h77, 0, 6'h00, 32'h0, 0);

        rst_n = 1'b0;
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
        bus.cpu_address = 8'h00; bus.cpu_writedata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busywait", 32'(bus.cpu_busywait), 32'd0);
        check("reset dm_read",  32'(bus.dm_read), 32'd0);
        check("reset dm_write", 32'(bus.dm_write), 32'd0);
        check("reset readdata", 32'(bus.cpu_readdata), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) apply(tbl[i]);
        check("memory holds written-back block", mem[1], 32'h44AB2211);

        // Reset while a fetch is outstanding
        bus.cpu_read = 1'b1; bus.cpu_address = 8'h88;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.dm_read && t < 50);
        check("fetch started before reset", 32'(bus.dm_read), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-fetch reset dm_read",  32'(bus.dm_read), 32'd0);
        check("mid-fetch reset dm_write", 32'(bus.dm_write), 32'd0);
        check("mid-fetch reset busywait", 32'(bus.cpu_busywait), 32'd0);
        @(posedge clk);
        #1;
        bus.cpu_read = 1'b0;
        rst_n = 1'b1;
        rebuild_ref();
        @(posedge clk);
        #1;
        apply(mk("re-miss 88", 1, 0, 8'h88, 8'h00, ref_b[8'h88], 0, 6'h00, 32'h0, 1));
        apply(mk("re-miss 05", 1, 0, 8'h05, 8'h00, ref_b[8'h05], 0, 6'h00, 32'h0, 1));

        // Write-miss every index, then read back written and unwritten bytes
        for (int i = 0; i < 8; i++) begin
            a = {3'd3, 3'(i), 2'(i)};
            apply(mk("sweep write", 0, 1, a, 8'hA0 + 8'(i), 8'h00, 0, 6'h00, 32'h0, 1));
        end
        for (int i = 0; i < 8; i++) begin
            a = {3'd3, 3'(i), 2'(i)};
            apply(mk("sweep read", 1, 0, a, 8'h00, 8'hA0 + 8'(i), 0, 6'h00, 32'h0, 0));
            a = {3'd3, 3'(i), 2'(i + 1)};
            apply(mk("sweep other byte", 1, 0, a, 8'h00, ref_b[a], 0, 6'h00, 32'h0, 0));
        end
        // Evict every dirty block with a new tag
        for (int i = 0; i < 8; i++) begin
            a = {3'd4, 3'(i), 2'd0};
            v = mk("sweep evict", 1, 0, a, 8'h00, ref_b[a], 1, {3'd3, 3'(i)},
                   ref_word({3'd3, 3'(i)}), 1);
            apply(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
